mem_bist_master: RTL and testbench
==================================

// Module: mem_bist_master
// PURPOSE
//  Initiator for the single-port SRAM valid/ready interface. On start_i it
//  writes a seeded pattern to every address, then reads each address back,
//  compares, and reports pass/fail, error count and first failing address.
//  Sits between the test/control logic and the SRAM port; it owns valid/wr_rd/addr/wdata.
// PARAMETERS
//  WIDTH      16             data width, matches the SRAM
//  DEPTH      64             number of words tested (addresses 0..DEPTH-1)
//  ADDR_SIZE  $clog2(DEPTH)  address width
//  TIMEOUT    8              max cycles waiting for ready_i per access
//  CNT_W      8              error counter width
// PORTS
//  clk_i              in   1          clock, all state on posedge
//  rst_ni             in   1          asynchronous, active-low reset
//  start_i            in   1          start test (sampled in IDLE/DONE only)
//  seed_i             in   WIDTH      pattern seed, latched when start accepted
//  valid_o            out  1          request valid to SRAM
//  wr_rd_o            out  1          1=write, 0=read
//  addr_o             out  ADDR_SIZE  request address
//  wdata_o            out  WIDTH      write data
//  ready_i            in   1          SRAM ready (registered, one cycle after request)
//  rdata_i            in   WIDTH      SRAM read data, valid while ready_i=1 on a read
//  busy_o             out  1          test in progress
//  done_o             out  1          test finished, held until next start
//  pass_o             out  1          1 if zero mismatches and no timeout (valid when done_o)
//  timeout_o          out  1          test aborted: ready_i not seen within TIMEOUT
//  err_cnt_o          out  CNT_W      mismatch count, saturates at 2^CNT_W-1
//  first_fail_addr_o  out  ADDR_SIZE  address of first mismatch (0 if none)
// BEHAVIOUR
//  Reset (async, rst_ni=0): state IDLE; all outputs 0; latched seed 0; counters 0.
//  Pattern: pat(a) = seed ^ a, a zero-extended (or truncated) to WIDTH.
//  FSM: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE.
//  IDLE/DONE: start_i=1 -> latch seed, clear err_cnt/first_fail/timeout/pass/done,
//   addr=0, go WR_REQ; busy_o=1 from next cycle.
//  *_REQ: valid_o=1 exactly one cycle with wr_rd_o/addr_o/wdata_o (wdata=pat(addr)
//   on writes, 0 on reads); go *_RSP.
//  *_RSP: valid_o=0; wait for ready_i=1; wait counter cleared on REQ entry.
//   RD_RSP with ready_i=1: compare rdata_i vs pat(addr); mismatch -> err_cnt+1
//   (saturating); on first mismatch capture addr into first_fail_addr_o.
//   On ready_i: addr==DEPTH-1 -> WR_RSP goes RD_REQ with addr=0, RD_RSP goes DONE;
//   else addr+1 and back to same-direction REQ.
//   No ready_i for TIMEOUT consecutive RSP cycles -> timeout_o=1, go DONE.
//  DONE: busy_o=0, done_o=1, pass_o=(err_cnt==0 && !timeout); outputs held.
//  Latency with ready_i one cycle after each request: 2 cycles/access;
//   done_o rises 4*DEPTH cycles after the edge that accepts start_i.
//  start_i while busy is ignored. ready_i outside RSP states is ignored.
//  Bus outputs (addr_o, wdata_o, wr_rd_o) return to 0 whenever valid_o=0.
//  rst_ni low mid-test: immediate return to IDLE, all outputs 0; no resume.
// TESTING
//  Good SRAM, seed=16'hA5A5, DEPTH=64 -> 64 writes then 64 reads,
//   wdata at addr 3 = 16'hA5A6; done_o after 256 cycles, pass_o=1, err_cnt_o=0.
//  SRAM model with bit 0 stuck-at-1 at addr 10 and 20, seed=0 -> pass_o=0,
//   err_cnt_o=2, first_fail_addr_o=10.
//  ready_i forced 0 from the 5th write on -> timeout_o=1, done_o=1, pass_o=0
//   exactly TIMEOUT cycles after that request; valid_o stays 0.
//  All 64 reads mismatched with CNT_W=4 -> err_cnt_o saturates at 15.
//  Pulse start_i mid-write phase -> ignored, sequence unchanged; assert rst_ni=0
//   at addr 30 -> all outputs 0 same cycle; new start runs full test, passes.
//  Second start from DONE with seed=16'hFFFF -> previous results cleared, pass_o=1.

Source files
------------

// File: rtl/mem_bist_master.sv
// Write-then-read BIST initiator for a single-port SRAM valid/ready port.
// IDLE idle | WR_REQ/RD_REQ issue access | WR_RSP/RD_RSP await ready | DONE results held
module mem_bist_master #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 64,
  parameter int ADDR_SIZE = $clog2(DEPTH),
  parameter int TIMEOUT   = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     seed_i,
  output logic                 valid_o,
  output logic                 wr_rd_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic [WIDTH-1:0]     wdata_o,
  input  logic                 ready_i,
  input  logic [WIDTH-1:0]     rdata_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic [ADDR_SIZE-1:0] first_fail_addr_o
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       seed_q, seed_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [TO_W-1:0]        wait_q, wait_d;
  logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
  logic [ADDR_SIZE-1:0]   first_fail_q, first_fail_d;
  logic                   timeout_q, timeout_d;
  logic                   pass_q, pass_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic                   wr_rd_q, wr_rd_d;
  logic [ADDR_SIZE-1:0]   req_addr_q, req_addr_d;
  logic [WIDTH-1:0]       wdata_q, wdata_d;
  logic [WIDTH-1:0]       pat_cur;

  assign pat_cur = seed_q ^ WIDTH'(addr_q);

  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    addr_d       = addr_q;
    wait_d       = wait_q;
    err_cnt_d    = err_cnt_q;
    first_fail_d = first_fail_q;
    timeout_d    = timeout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          seed_d       = seed_i;
          addr_d       = '0;
          err_cnt_d    = '0;
          first_fail_d = '0;
          timeout_d    = 1'b0;
          state_d      = WR_REQ;
        end
      end
      WR_REQ: state_d = WR_RSP;
      RD_REQ: state_d = RD_RSP;
      WR_RSP, RD_RSP: begin
        if (ready_i) begin
          if (state_q == RD_RSP && rdata_i != pat_cur) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (err_cnt_q == '0) first_fail_d = addr_q;
          end
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = (state_q == WR_RSP) ? RD_REQ : DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = (state_q == WR_RSP) ? WR_REQ : RD_REQ;
          end
        end else if (wait_q <= TO_W'(1)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    if (state_d == WR_REQ || state_d == RD_REQ) wait_d = TO_W'(TIMEOUT);
    valid_d    = (state_d == WR_REQ) || (state_d == RD_REQ);
    wr_rd_d    = (state_d == WR_REQ);
    req_addr_d = valid_d ? addr_d : '0;
    wdata_d    = (state_d == WR_REQ) ? (seed_d ^ WIDTH'(addr_d)) : '0;
    busy_d     = valid_d || (state_d == WR_RSP) || (state_d == RD_RSP);
    done_d     = (state_d == DONE);
    pass_d     = done_d && (err_cnt_d == '0) && !timeout_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      seed_q       <= '0;
      addr_q       <= '0;
      wait_q       <= '0;
      err_cnt_q    <= '0;
      first_fail_q <= '0;
      timeout_q    <= 1'b0;
      pass_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      wr_rd_q      <= 1'b0;
      req_addr_q   <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      addr_q       <= addr_d;
      wait_q       <= wait_d;
      err_cnt_q    <= err_cnt_d;
      first_fail_q <= first_fail_d;
      timeout_q    <= timeout_d;
      pass_q       <= pass_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      wr_rd_q      <= wr_rd_d;
      req_addr_q   <= req_addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign valid_o           = valid_q;
  assign wr_rd_o           = wr_rd_q;
  assign addr_o            = req_addr_q;
  assign wdata_o           = wdata_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign timeout_o         = timeout_q;
  assign err_cnt_o         = err_cnt_q;
  assign first_fail_addr_o = first_fail_q;

endmodule

// File: tb/tb_mem_bist_master.sv
// Directed bench: scoreboard of expected SRAM requests plus end-of-test result checks.
module tb_mem_bist_master;

  localparam int W  = 16;
  localparam int D  = 64;
  localparam int AW = 6;
  localparam int TO = 8;

  logic          clk_i, rst_ni, start_i;
  logic [W-1:0]  seed_i;
  logic          valid_o, wr_rd_o, ready_i;
  logic [AW-1:0] addr_o, first_fail_addr_o;
  logic [W-1:0]  wdata_o, rdata_i;
  logic          busy_o, done_o, pass_o, timeout_o;
  logic [7:0]    err_cnt_o;

  logic          v2, wr2, rdy2, busy2, done2, pass2, to2;
  logic [AW-1:0] a2, ff2;
  logic [W-1:0]  wd2, rd2;
  logic [3:0]    err2;

  logic          kill_en, fault_en;
  logic [W-1:0]  mem1 [D];
  logic [W-1:0]  mem2 [D];

  int total, bad;
  logic [22:0] sb[$];

  mem_bist_master #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .seed_i(seed_i),
    .valid_o(valid_o), .wr_rd_o(wr_rd_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .ready_i(ready_i), .rdata_i(rdata_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .timeout_o(timeout_o), .err_cnt_o(err_cnt_o),
    .first_fail_addr_o(first_fail_addr_o));

  // Narrow error counter against an SRAM that corrupts every read.
  mem_bist_master #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO), .CNT_W(4)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .seed_i(seed_i),
    .valid_o(v2), .wr_rd_o(wr2), .addr_o(a2), .wdata_o(wd2),
    .ready_i(rdy2), .rdata_i(rd2), .busy_o(busy2), .done_o(done2),
    .pass_o(pass2), .timeout_o(to2), .err_cnt_o(err2),
    .first_fail_addr_o(ff2));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_i <= 1'b0;
      rdata_i <= '0;
    end else begin
      ready_i <= valid_o && !(kill_en && wr_rd_o && addr_o >= 6'd4);
      if (valid_o && wr_rd_o) mem1[addr_o] <= wdata_o;
      rdata_i <= (valid_o && !wr_rd_o)
               ? (mem1[addr_o] | {15'b0, fault_en && (addr_o == 6'd10 || addr_o == 6'd20)})
               : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy2 <= 1'b0;
      rd2  <= '0;
    end else begin
      rdy2 <= v2;
      if (v2 && wr2) mem2[a2] <= wd2;
      rd2 <= (v2 && !wr2) ? ~mem2[a2] : '0;
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    logic [22:0] e;
    int sz;
    @(posedge clk_i);
    @(negedge clk_i);
    if (valid_o) begin
      sz = sb.size();
      check("sb_underflow", (sz > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sz > 0) begin
        e = sb.pop_front();
        check("sb_request", {9'b0, wr_rd_o, addr_o, wdata_o}, {9'b0, e});
      end
    end else begin
      check("bus_idle", {9'b0, wr_rd_o, addr_o, wdata_o}, 32'd0);
    end
  endtask

  task automatic start_test(input logic [W-1:0] s, input int nwr, input int nrd);
    for (int a = 0; a < nwr; a++) sb.push_back({1'b1, AW'(a), s ^ W'(a)});
    for (int a = 0; a < nrd; a++) sb.push_back({1'b0, AW'(a), 16'h0000});
    seed_i  = s;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int n, input int lim);
    n = 0;
    while (!done_o && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {busy_o, done_o, pass_o, timeout_o, valid_o, wr_rd_o, addr_o,
                 err_cnt_o, first_fail_addr_o}, 32'd0);
    check({name, "_wdata"}, {16'b0, wdata_o}, 32'd0);
  endtask

  initial begin
    int n;
    total = 0; bad = 0;
    rst_ni = 1'b0; start_i = 1'b0; seed_i = '0; kill_en = 1'b0; fault_en = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset_state");
    rst_ni = 1'b1;
    tick();
    check_outputs_zero("idle_state");

    // Good SRAM, seed A5A5.
    start_test(16'hA5A5, D, D);
    check("t1_busy", {31'b0, busy_o}, 32'd1);
    check("t1_done_low", {31'b0, done_o}, 32'd0);
    wait_done(n, 400);
    check("t1_latency", n, 32'd256);
    check("t1_pass", {31'b0, pass_o}, 32'd1);
    check("t1_err", {24'b0, err_cnt_o}, 32'd0);
    check("t1_first", {26'b0, first_fail_addr_o}, 32'd0);
    check("t1_timeout", {31'b0, timeout_o}, 32'd0);
    check("t1_busy_end", {31'b0, busy_o}, 32'd0);
    check("t1_sb_empty", sb.size(), 32'd0);
    check("sat_done", {31'b0, done2}, 32'd1);
    check("sat_err", {28'b0, err2}, 32'd15);
    check("sat_pass", {31'b0, pass2}, 32'd0);
    check("sat_first", {26'b0, ff2}, 32'd0);
    tick();
    check("t1_hold_done", {31'b0, done_o}, 32'd1);
    check("t1_hold_pass", {31'b0, pass_o}, 32'd1);

    // Stuck-at-1 on bit 0 at addresses 10 and 20, seed 0.
    fault_en = 1'b1;
    start_test(16'h0000, D, D);
    wait_done(n, 400);
    check("t2_latency", n, 32'd256);
    check("t2_pass", {31'b0, pass_o}, 32'd0);
    check("t2_err", {24'b0, err_cnt_o}, 32'd2);
    check("t2_first", {26'b0, first_fail_addr_o}, 32'd10);
    check("t2_timeout", {31'b0, timeout_o}, 32'd0);
    fault_en = 1'b0;

    // Restart from DONE clears previous failing results.
    start_test(16'hFFFF, D, D);
    check("t3_done_clr", {31'b0, done_o}, 32'd0);
    check("t3_pass_clr", {31'b0, pass_o}, 32'd0);
    check("t3_err_clr", {24'b0, err_cnt_o}, 32'd0);
    check("t3_first_clr", {26'b0, first_fail_addr_o}, 32'd0);
    check("t3_busy", {31'b0, busy_o}, 32'd1);
    wait_done(n, 400);
    check("t3_latency", n, 32'd256);
    check("t3_pass", {31'b0, pass_o}, 32'd1);
    check("t3_err", {24'b0, err_cnt_o}, 32'd0);

    // ready_i withheld from the fifth write onwards.
    kill_en = 1'b1;
    start_test(16'h1234, 5, 0);
    n = 0;
    while (!(valid_o && wr_rd_o && addr_o == 6'd4) && n < 40) begin
      tick();
      n++;
    end
    check("t4_saw_5th_write", (n < 40) ? 32'd1 : 32'd0, 32'd1);
    tick();
    wait_done(n, 40);
    check("t4_timeout_lat", n, TO);
    check("t4_timeout", {31'b0, timeout_o}, 32'd1);
    check("t4_done", {31'b0, done_o}, 32'd1);
    check("t4_pass", {31'b0, pass_o}, 32'd0);
    check("t4_busy", {31'b0, busy_o}, 32'd0);
    check("t4_sb_empty", sb.size(), 32'd0);
    kill_en = 1'b0;

    // start_i ignored mid-run, then reset at address 30.
    start_test(16'h5A5A, D, D);
    repeat (20) tick();
    seed_i  = 16'h0000;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    while (!(valid_o && wr_rd_o && addr_o == 6'd30) && n < 100) begin
      tick();
      n++;
    end
    check("t5_saw_addr30", (n < 100) ? 32'd1 : 32'd0, 32'd1);
    rst_ni = 1'b0;
    #1;
    check_outputs_zero("t5_async_reset");
    sb.delete();
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    check_outputs_zero("t5_after_reset");
    start_test(16'h3C3C, D, D);
    wait_done(n, 400);
    check("t5_latency", n, 32'd256);
    check("t5_pass", {31'b0, pass_o}, 32'd1);
    check("t5_err", {24'b0, err_cnt_o}, 32'd0);
    check("t5_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
